mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit for the multi-cycle CPU.
- Directly upstream of the immediate extender: it generates ext_op together with every other datapath strobe.
- Moore-style FSM (IF/ID/EXE/MEM/WB). Its inputs are the latched opcode/funct, the ALU zero flag and a memory-ready handshake.
- Outputs go to the PC, IR, register file, ALU, data memory and extender.

Parameters:
MEM_WAIT_MAX, 0, max cycles spent in MEM waiting for mem_rdy; 0 = wait forever, N>0 = abort after N cycles with mem_err.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from ID until the next IF
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, valid in EXE
mem_rdy  in  1  data memory completion, sampled in MEM
pc_wr  out  1  PC write enable
npc_sel  out  2  00 pc+4, 01 branch target, 10 jump target
ir_wr  out  1  IR write enable
ext_op  out  1  1 sign-extend, 0 zero-extend
alu_src  out  1  0 rt, 1 extended immediate
alu_ctrl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 LUI
reg_wr  out  1  register file write enable
reg_dst  out  2  00 rt, 01 rd, 10 r31
wd_sel  out  2  00 ALU result, 01 memory data, 10 link (pc+4)
mem_rd  out  1  data memory read strobe
mem_wr  out  1  data memory write strobe
illegal  out  1  one-cycle pulse on an undecodable instruction
mem_err  out  1  one-cycle pulse on a MEM timeout
state  out  3  current state, debug

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IF, wait counter=0.
  - Every output is 0 while rst_n=0, including pc_wr, ir_wr and state.
  - Reset mid-instruction aborts it; a pending sw is never written.
- Opcode set:
  - R 000000 with funct addu 100001, subu 100011, and 100100, or 100101, slt 101010.
  - ori 001101, lui 001111, addiu 001001, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- Outputs are combinational from the registered state plus opcode/funct. Any output not listed for a state is 0.
- ext_op depends on opcode only and is held in every state: 1 for addiu/lw/sw/beq, 0 otherwise.
- alu_ctrl depends on opcode/funct in every state:
  - R-type: per funct.
  - addiu/lw/sw: ADD.
  - beq: SUB.
  - ori: OR.
  - lui: LUI.
  - everything else: ADD.
- IF: ir_wr=1, pc_wr=1, npc_sel=00. Next state ID.
- ID:
  - j: pc_wr=1, npc_sel=10, then IF.
  - jal: pc_wr=1, npc_sel=10, reg_wr=1, reg_dst=10, wd_sel=10, then IF.
  - Unknown opcode, or R-type with unknown funct: illegal=1, no writes, then IF.
  - All others: EXE.
- EXE:
  - alu_src=1 for ori/lui/addiu/lw/sw; alu_src=0 for R-type/beq.
  - beq: npc_sel=01, pc_wr=zero, then IF.
  - lw/sw: then MEM.
  - R/ori/lui/addiu: then WB.
- MEM:
  - lw: mem_rd=1. sw: mem_wr=1.
  - Strobes stay asserted until mem_rdy=1. mem_rdy=1 in the first MEM cycle gives 1-cycle MEM.
  - On mem_rdy: lw goes to WB, sw goes to IF.
  - If MEM_WAIT_MAX>0 and the counter reaches MEM_WAIT_MAX with mem_rdy still 0: mem_err=1 that cycle, go to IF, no register write.
  - The counter clears on entry to MEM. mem_rdy in the timeout cycle takes priority over the timeout.
- WB: reg_wr=1.
  - reg_dst=01 for R-type, 00 otherwise.
  - wd_sel=01 for lw, 00 otherwise.
  - Next state IF.
- mem_rdy outside MEM is ignored.
- Latency in cycles:
  - j/jal: 2.
  - beq: 3.
  - R/I ALU: 4.
  - sw: 4 + stalls.
  - lw: 5 + stalls.

Decomposition:
- Shared package mc_pkg holds the opcode and funct localparams, the alu_ctrl codes, the npc_sel/reg_dst/wd_sel encodings and the state encoding (IF=0, ID=1, EXE=2, MEM=3, WB=4).
- Natural sub-module: mc_dec, combinational. It maps opcode/funct to an instruction class plus the legal flag, ext_op and alu_ctrl.
- mc_ctrl holds the state register, the wait counter and the per-state strobe logic.

Test Plan:
- Reset: rst_n=0 mid-EXE of addiu -> state=0 and all outputs 0 the same cycle. After release, the first edge is in IF with ir_wr=1, pc_wr=1.
- addiu (001001) then ori (001101): IF,ID,EXE,WB each -> in EXE ext_op=1 then ext_op=0, alu_src=1, alu_ctrl 000 then 011. WB has reg_wr=1, reg_dst=00, wd_sel=00.
- beq with zero=1 vs zero=0 -> in EXE npc_sel=01, pc_wr=1 (resp. 0), alu_ctrl=001. Next state IF; 3 cycles total.
- lw with mem_rdy low for 3 MEM cycles, MEM_WAIT_MAX=0 -> mem_rd=1 held 4 cycles, then WB with wd_sel=01. sw with mem_rdy=1 immediately -> mem_wr=1 for one cycle, then IF.
- MEM_WAIT_MAX=2, sw, mem_rdy stuck 0 -> mem_err pulses once, returns to IF, reg_wr never 1.
- jal -> ID asserts pc_wr=1, npc_sel=10, reg_wr=1, reg_dst=10, wd_sel=10. Opcode 111111 -> illegal=1 in ID with no writes, next state IF.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// datapath select codes, FSM states and the decoded instruction classes.
package mc_pkg;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_LUI  = 3'b101;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_R31   = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_LINK  = 2'b10;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE,
        C_ORI,
        C_LUI,
        C_ADDIU,
        C_LW,
        C_SW,
        C_BEQ,
        C_J,
        C_JAL,
        C_ILL
    } iclass_t;

endpackage

// File: rtl/mc_dec.sv
// Combinational instruction decoder: opcode/funct to instruction class,
// legality, extender mode and ALU operation.
module mc_dec
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic       legal,
    output logic       ext_op,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        iclass   = C_ILL;
        alu_ctrl = ALU_ADD;
        case (opcode)
            OP_R: begin
                iclass = C_RTYPE;
                case (funct)
                    FN_ADDU: alu_ctrl = ALU_ADD;
                    FN_SUBU: alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: iclass   = C_ILL;
                endcase
            end
            OP_ORI: begin
                iclass   = C_ORI;
                alu_ctrl = ALU_OR;
            end
            OP_LUI: begin
                iclass   = C_LUI;
                alu_ctrl = ALU_LUI;
            end
            OP_ADDIU: iclass = C_ADDIU;
            OP_LW:    iclass = C_LW;
            OP_SW:    iclass = C_SW;
            OP_BEQ: begin
                iclass   = C_BEQ;
                alu_ctrl = ALU_SUB;
            end
            OP_J:     iclass = C_J;
            OP_JAL:   iclass = C_JAL;
            default:  iclass = C_ILL;
        endcase
    end

    assign legal = (iclass != C_ILL);

    // Extender mode follows the opcode alone, so an illegal funct cannot change it.
    assign ext_op = (opcode == OP_ADDIU) || (opcode == OP_LW) ||
                    (opcode == OP_SW)    || (opcode == OP_BEQ);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB) with Moore-style datapath
// strobes, a bounded memory wait and illegal-instruction reporting.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       pc_wr,
    output logic [1:0] npc_sel,
    output logic       ir_wr,
    output logic       ext_op,
    output logic       alu_src,
    output logic [2:0] alu_ctrl,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       illegal,
    output logic       mem_err,
    output logic [2:0] state
);

    localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);
    localparam logic [CNT_W-1:0] WAIT_LAST =
        CNT_W'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_to;

    iclass_t          iclass;
    logic             legal;
    logic             dec_ext;
    logic [2:0]       dec_alu;

    mc_dec u_dec (
        .opcode   (opcode),
        .funct    (funct),
        .iclass   (iclass),
        .legal    (legal),
        .ext_op   (dec_ext),
        .alu_ctrl (dec_alu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Counts completed MEM cycles; any cycle not staying in MEM clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_q != S_MEM || state_d != S_MEM) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign mem_to = (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_LAST);
    assign state  = state_q;

    always_comb begin
        state_d  = state_q;
        pc_wr    = 1'b0;
        npc_sel  = NPC_PC4;
        ir_wr    = 1'b0;
        ext_op   = dec_ext;
        alu_src  = 1'b0;
        alu_ctrl = dec_alu;
        reg_wr   = 1'b0;
        reg_dst  = RD_RT;
        wd_sel   = WD_ALU;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        illegal  = 1'b0;
        mem_err  = 1'b0;

        case (state_q)
            S_IF: begin
                ir_wr   = 1'b1;
                pc_wr   = 1'b1;
                npc_sel = NPC_PC4;
                state_d = S_ID;
            end
            S_ID: begin
                if (!legal) begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end else begin
                    case (iclass)
                        C_J: begin
                            pc_wr   = 1'b1;
                            npc_sel = NPC_JMP;
                            state_d = S_IF;
                        end
                        C_JAL: begin
                            pc_wr   = 1'b1;
                            npc_sel = NPC_JMP;
                            reg_wr  = 1'b1;
                            reg_dst = RD_R31;
                            wd_sel  = WD_LINK;
                            state_d = S_IF;
                        end
                        default: state_d = S_EXE;
                    endcase
                end
            end
            S_EXE: begin
                alu_src = (iclass == C_ORI) || (iclass == C_LUI) ||
                          (iclass == C_ADDIU) || (iclass == C_LW) ||
                          (iclass == C_SW);
                case (iclass)
                    C_BEQ: begin
                        npc_sel = NPC_BR;
                        pc_wr   = zero;
                        state_d = S_IF;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_rd = (iclass == C_LW);
                mem_wr = (iclass == C_SW);
                // A completion in the last allowed cycle wins over the timeout.
                if (mem_rdy) begin
                    state_d = (iclass == C_LW) ? S_WB : S_IF;
                end else if (mem_to) begin
                    mem_err = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB: begin
                reg_wr  = 1'b1;
                reg_dst = (iclass == C_RTYPE) ? RD_RD : RD_RT;
                wd_sel  = (iclass == C_LW) ? WD_MEM : WD_ALU;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // Reset forces every strobe low at once, so an aborted store never fires.
        if (!rst_n) begin
            pc_wr    = 1'b0;
            npc_sel  = 2'b00;
            ir_wr    = 1'b0;
            ext_op   = 1'b0;
            alu_src  = 1'b0;
            alu_ctrl = 3'b000;
            reg_wr   = 1'b0;
            reg_dst  = 2'b00;
            wd_sel   = 2'b00;
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            illegal  = 1'b0;
            mem_err  = 1'b0;
        end
    end

endmodule
